// File: rtl/serial_adder.sv
// serial_adder: bit-serial, LSB-first adder of two WIDTH-bit operands.
// One result bit is produced per clock. Each bit goes through a full adder
// built from two half_adder cells and an OR. A single carry flop links each
// bit to the next.
//
// Ports
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   start_i  request; sampled only in IDLE
//   a_i/b_i  operands; captured on the accepting edge
//   busy_o   high while bits are being shifted
//   done_o   one-cycle pulse; sum_o/cout_o hold the new result
//   sum_o    (a+b) mod 2^WIDTH
//   cout_o   carry out of the MSB
//
// state | meaning
// IDLE  | waiting for start_i
// SHIFT | one operand bit summed per clock, WIDTH clocks
// DONE  | result published, done_o pulse, back to IDLE next edge

module half_adder (
    input  logic a_i,
    input  logic b_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i;
    assign c_o = a_i & b_i;
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    count_q, count_d;

    logic s1, c1, s_bit, c2, carry_nxt;

    half_adder u_ha0 (.a_i(opa_q[0]), .b_i(opb_q[0]), .s_o(s1),    .c_o(c1));
    half_adder u_ha1 (.a_i(s1),       .b_i(carry_q),  .s_o(s_bit), .c_o(c2));

    assign carry_nxt = c1 | c2;

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        count_d = count_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    opa_d   = a_i;
                    opb_d   = b_i;
                    carry_d = 1'b0;
                    count_d = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                res_d   = {s_bit, res_q[WIDTH-1:1]};
                opa_d   = opa_q >> 1;
                opb_d   = opb_q >> 1;
                carry_d = carry_nxt;
                count_d = count_q + CW'(1);
                if (count_q == LAST) begin
                    // Outputs change only here so they stay stable between results.
                    sum_d   = res_d;
                    cout_d  = carry_nxt;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            count_q <= count_d;
        end
    end

    assign busy_o = (state_q == S_SHIFT);
    assign done_o = (state_q == S_DONE);
    assign sum_o  = sum_q;
    assign cout_o = cout_q;

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial, LSB-first adder of two WIDTH-bit operands. Each bit is summed by a full-adder stage built from two half_adder instances and an OR for the carry.
- A single carry flip-flop links one bit to the next, so one result bit is produced per clock.
- Sits directly downstream of the half_adder cell: it consumes the half-adder sum/carry outputs and turns the combinational cell into a multi-bit sequential datapath.
- Start/busy/done handshake toward the controlling logic.

Parameters:
- WIDTH, 8, operand and result width in bits (≥2).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse; sum/cout valid.
- sum  output  WIDTH  result (a+b) mod 2^WIDTH.
- cout  output  1  carry out of the MSB.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While rst_n=0:
  - state=IDLE; busy=0; done=0; sum=0; cout=0.
  - Internal shift registers, carry flop and bit counter are all cleared.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - When start=1 at an edge: load a→opA and b→opB; carry←0; count←0; go to SHIFT.
  - When start=0: stay in IDLE.
- SHIFT (busy=1), each edge:
  - s = opA[0]^opB[0]^carry, formed as half_adder(opA[0],opB[0]) → (s1,c1), then half_adder(s1,carry) → (s,c2).
  - carry ← c1|c2.
  - Result shift register shifts right with s into the MSB; opA and opB shift right.
  - count increments.
  - On the edge where count==WIDTH-1 (the WIDTH-th bit): go to DONE; sum ← completed result; cout ← final carry.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then IDLE on the next edge.
  - start in DONE is ignored and is not queued.
- Latency:
  - start sampled at edge E0; busy high for WIDTH cycles; done high in the cycle after edge E0+WIDTH.
  - Back-to-back throughput: one result per WIDTH+2 cycles. The earliest re-accept is the edge ending the first IDLE cycle after DONE.
- Output hold:
  - sum and cout update only on entry to DONE.
  - They hold their value through IDLE and through the next operation until the next DONE, so they are stable between results.
  - sum and cout are not updated bit-by-bit while busy.
- start while busy/DONE: ignored; no effect on the operands or result.
- a/b changes after acceptance: no effect; operands are captured only on the accepting edge.
- Overflow: sum wraps modulo 2^WIDTH, and cout carries the overflow bit. No saturation.
- Reset mid-operation: immediate abort; all outputs and state return to reset values; no done pulse.
- X on start in IDLE: treated as not-start by design intent. The bench must drive start as 0 or 1 only.

Test Plan:
- WIDTH=8, reset released, start pulse with a=8'h5A, b=8'h33 → busy high 8 cycles; done pulse in cycle 9 after acceptance; sum=8'h8D, cout=0.
- a=8'hFF, b=8'h01 → sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF → sum=8'hFE, cout=1. Then a=0, b=0 → sum=0, cout=0.
- Accept a=8'h10, b=8'h20. Then assert start with a=8'hFF, b=8'hFF at SHIFT cycle 3 and again during DONE → single result sum=8'h30, cout=0; exactly one done pulse; busy never retriggered.
- Accept a=8'hAA, b=8'h55, then drop rst_n at SHIFT cycle 4 → busy=0, done=0, sum=0, cout=0 immediately (asynchronously). No done pulse after release. A fresh start with 8'h01+8'h01 gives sum=8'h02.
- Back-to-back: hold start=1 continuously with a=8'h0F, b=8'h01 → results sum=8'h10 separated by WIDTH+2 cycles; done is one cycle wide each time; sum is stable between pulses.
- WIDTH=4: a=4'hF, b=4'hF → sum=4'hE, cout=1, done 5 cycles after acceptance. Plus an exhaustive 256-pair sweep checked against a+b.
